// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: shares IM/RF/ALU/DM across IF/ID/EX/MEM/WB/BR/JMP states.
// Optional MIPS_MC_ILLEGAL_TRAP_EN: illegal opcodes park the core in TRAP with halt=1.
module mips_mc_ctrl #(
  parameter int MEM_WAIT = 0,
  parameter int ALUOP_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         funct,
  input  logic               Zero,
  output logic               PCWr,
  output logic               IRWr,
  output logic               RFWr,
  output logic               DMWr,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               ALUSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         NPCOp,
  output logic [1:0]         EXTOp,
  output logic               jal_signal,
  output logic [2:0]         state,
  output logic               instr_done,
  output logic               halt
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_BR   = 3'd5,
    S_JMP  = 3'd6,
    S_TRAP = 3'd7
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_LUI  = 4'd8;
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state_reg, state_next;
  logic [3:0] wait_reg, wait_next;
  logic       wait_last;

  logic is_rtype, is_jr, r_alu, is_addi, is_ori, is_lui, is_lw, is_sw;
  logic is_beq, is_bne, is_j, is_jal;
  logic [3:0] aluop_dec;

  assign is_rtype = (OpCode == 6'b000000);
  assign is_jr    = is_rtype && (funct == 6'b001000);
  assign is_addi  = (OpCode == 6'b001000) || (OpCode == 6'b001001);
  assign is_ori   = (OpCode == 6'b001101);
  assign is_lui   = (OpCode == 6'b001111);
  assign is_lw    = (OpCode == 6'b100011);
  assign is_sw    = (OpCode == 6'b101011);
  assign is_beq   = (OpCode == 6'b000100);
  assign is_bne   = (OpCode == 6'b000101);
  assign is_j     = (OpCode == 6'b000010);
  assign is_jal   = (OpCode == 6'b000011);

  // R-type ALU decode; r_alu flags the supported funct codes
  always_comb begin
    aluop_dec = ALU_ADD;
    r_alu     = 1'b0;
    if (is_rtype) begin
      r_alu = 1'b1;
      case (funct)
        6'b100001: aluop_dec = ALU_ADD;
        6'b100011: aluop_dec = ALU_SUB;
        6'b100100: aluop_dec = ALU_AND;
        6'b100101: aluop_dec = ALU_OR;
        6'b101010: aluop_dec = ALU_SLT;
        6'b000000: aluop_dec = ALU_SLL;
        6'b000010: aluop_dec = ALU_SRL;
        default:   r_alu     = 1'b0;
      endcase
    end else if (is_ori) begin
      aluop_dec = ALU_OR;
    end else if (is_lui) begin
      aluop_dec = ALU_LUI;
    end
  end

  assign wait_last = (wait_reg == WAIT_LAST);
  assign state     = state_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IF;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    wait_next  = '0;
    PCWr       = 1'b0;
    IRWr       = 1'b0;
    RFWr       = 1'b0;
    DMWr       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrc     = 1'b0;
    ALUOp      = '0;
    NPCOp      = 2'b00;
    EXTOp      = 2'b00;
    jal_signal = 1'b0;
    instr_done = 1'b0;
    halt       = 1'b0;
    case (state_reg)
      S_IF: begin
        if (wait_last) begin
          IRWr       = 1'b1;
          PCWr       = 1'b1;
          state_next = S_ID;
        end else begin
          wait_next = wait_reg + 4'd1;
        end
      end
      S_ID: begin
        if (is_jr || is_j || is_jal) begin
          state_next = S_JMP;
        end else if (r_alu || is_addi || is_ori || is_lui || is_lw || is_sw) begin
          state_next = S_EX;
        end else if (is_beq || is_bne) begin
          state_next = S_BR;
        end else begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
          state_next = S_TRAP;
`else
          instr_done = 1'b1;
          state_next = S_IF;
`endif
        end
      end
      S_EX: begin
        ALUOp      = ALUOP_W'(aluop_dec);
        ALUSrc     = !is_rtype;
        EXTOp      = is_ori ? 2'b00 : (is_lui ? 2'b10 : 2'b01);
        state_next = (is_lw || is_sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        ALUOp  = ALUOP_W'(ALU_ADD);
        ALUSrc = 1'b1;
        EXTOp  = 2'b01;
        if (wait_last) begin
          if (is_sw) begin
            DMWr       = 1'b1;
            instr_done = 1'b1;
            state_next = S_IF;
          end else begin
            state_next = S_WB;
          end
        end else begin
          wait_next = wait_reg + 4'd1;
        end
      end
      S_WB: begin
        RFWr       = 1'b1;
        instr_done = 1'b1;
        RegDst     = is_rtype;
        MemtoReg   = is_lw;
        state_next = S_IF;
      end
      S_BR: begin
        // PC already holds PC+4 here, so the NPC unit offsets from it directly
        ALUOp      = ALUOP_W'(ALU_SUB);
        NPCOp      = 2'b01;
        PCWr       = is_beq ? Zero : !Zero;
        instr_done = 1'b1;
        state_next = S_IF;
      end
      S_JMP: begin
        PCWr       = 1'b1;
        instr_done = 1'b1;
        NPCOp      = is_jr ? 2'b11 : 2'b10;
        RFWr       = is_jal;
        jal_signal = is_jal;
        state_next = S_IF;
      end
      S_TRAP: begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
        halt       = 1'b1;
        state_next = S_TRAP;
`else
        state_next = S_IF;
`endif
      end
      default: state_next = S_IF;
    endcase
    // reset cycle aborts whatever is in flight without any side effect
    if (rst) begin
      PCWr       = 1'b0;
      IRWr       = 1'b0;
      RFWr       = 1'b0;
      DMWr       = 1'b0;
      instr_done = 1'b0;
      halt       = 1'b0;
    end
  end

endmodule
